// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: shared request type, bus widths and round-robin pick for the memory arbiter
package memory_arbiter_pkg;
  localparam int NUM_MASTERS = 2;
  localparam int DATA_WIDTH = 24;
  localparam int ADDRESS_WIDTH = 32;
  localparam int MASTER_ID_WIDTH = 8;
  localparam int PTR_WIDTH = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;
  typedef struct packed {
    logic [MASTER_ID_WIDTH-1:0] id;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data;
    logic write;
  } request_t;
  typedef struct packed {
    logic hit;
    logic [PTR_WIDTH-1:0] idx;
  } pick_t;
  function automatic pick_t rr_pick(input logic [NUM_MASTERS-1:0] valid, input logic [PTR_WIDTH-1:0] ptr);
    pick_t p;
    p = '0;
    // scan backwards so the candidate closest to ptr wins
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      int j;
      j = (int'(ptr) + k) % NUM_MASTERS;
      if (valid[j]) p = '{hit: 1'b1, idx: PTR_WIDTH'(j)};
    end
    return p;
  endfunction
endpackage

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: N-lane memory bus (request + response channels) with master/slave views
interface memory_arbiter_if import memory_arbiter_pkg::*; #(parameter int N = 1);
  logic [N-1:0][MASTER_ID_WIDTH-1:0] req_id;
  logic [N-1:0][ADDRESS_WIDTH-1:0] req_address;
  logic [N-1:0][DATA_WIDTH-1:0] req_data;
  logic [N-1:0] req_write;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_taken;
  logic [MASTER_ID_WIDTH-1:0] rsp_id;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [N-1:0] rsp_valid;
  logic [N-1:0] rsp_taken;
  modport master (output req_id, req_address, req_data, req_write, req_valid, rsp_taken,
                  input req_taken, rsp_id, rsp_data, rsp_valid);
  modport slave (input req_id, req_address, req_data, req_write, req_valid, rsp_taken,
                 output req_taken, rsp_id, rsp_data, rsp_valid);
endinterface

// File: rtl/memory_request_slot.sv
// memory_request_slot: one-entry valid/taken register stage that refills in the cycle it drains
module memory_request_slot import memory_arbiter_pkg::*; (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     in_valid,
  input  request_t in_req,
  output logic     in_ready,
  output logic     out_valid,
  output request_t out_req,
  input  logic     out_taken
);
  assign in_ready = !out_valid || out_taken;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_req <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_req <= in_req;
    end
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin merge of master requests onto one memory bus, responses routed by ID range
module memory_arbiter import memory_arbiter_pkg::*; #(
  parameter int MASTER_ID_BASE = 4,
  parameter int ID_SPAN = 4
) (
  input  logic clk,
  input  logic rst_n,
  memory_arbiter_if.slave  up,
  memory_arbiter_if.master dn,
  output logic id_error
);
  typedef logic [MASTER_ID_WIDTH:0] ext_t;
  localparam ext_t LO = ext_t'(MASTER_ID_BASE);
  localparam ext_t HI = ext_t'(MASTER_ID_BASE + NUM_MASTERS * ID_SPAN);
  localparam ext_t SPAN = ext_t'(ID_SPAN);
  logic [PTR_WIDTH-1:0] ptr, owner;
  pick_t pick;
  logic free, take, ms_valid, in_range;
  request_t in_req, ms_req;
  ext_t ext, off;
  assign pick = rr_pick(up.req_valid, ptr);
  assign take = rst_n && free && pick.hit;
  assign up.req_taken = take ? NUM_MASTERS'(1) << pick.idx : '0;
  assign in_req = '{id: up.req_id[pick.idx], address: up.req_address[pick.idx],
                    data: up.req_data[pick.idx], write: up.req_write[pick.idx]};
  memory_request_slot u_slot (
    .clk(clk), .rst_n(rst_n), .in_valid(take), .in_req(in_req), .in_ready(free),
    .out_valid(ms_valid), .out_req(ms_req), .out_taken(dn.req_taken[0])
  );
  assign dn.req_valid[0] = ms_valid;
  assign dn.req_id[0] = ms_req.id;
  assign dn.req_address[0] = ms_req.address;
  assign dn.req_data[0] = ms_req.data;
  assign dn.req_write[0] = ms_req.write;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (take) ptr <= pick.idx == PTR_WIDTH'(NUM_MASTERS - 1) ? '0 : pick.idx + 1'b1;
  // one extra bit keeps the range compare from wrapping near the top of the ID space
  assign ext = {1'b0, dn.rsp_id};
  assign in_range = ext >= LO && ext < HI;
  assign off = ext - LO;
  assign owner = PTR_WIDTH'(off / SPAN);
  assign up.rsp_id = dn.rsp_id;
  assign up.rsp_data = dn.rsp_data;
  assign up.rsp_valid = in_range && dn.rsp_valid[0] ? NUM_MASTERS'(1) << owner : '0;
  assign dn.rsp_taken[0] = in_range ? up.rsp_taken[owner] : 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) id_error <= 1'b0;
    else if (dn.rsp_valid[0] && !in_range) id_error <= 1'b1;
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed stimulus with a request scoreboard checked by an independent bus monitor
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_error;
  int tests = 0;
  int fails = 0;
  request_t exp_q[$];
  logic [7:0] bid [4] = '{8'd4, 8'd7, 8'd8, 8'd11};
  logic [1:0] bv [4] = '{2'b01, 2'b01, 2'b10, 2'b10};
  logic [7:0] oid [3] = '{8'd2, 8'd12, 8'd255};
  memory_arbiter_if #(.N(NUM_MASTERS)) up ();
  memory_arbiter_if #(.N(1)) dn ();
  memory_arbiter dut (.clk(clk), .rst_n(rst_n), .up(up), .dn(dn), .id_error(id_error));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic request_t req(input int i, input logic [31:0] addr);
    return '{id: MASTER_ID_WIDTH'(4 + 4 * i), address: addr,
             data: DATA_WIDTH'(addr) ^ 24'h5a5a5, write: i == 1};
  endfunction
  task automatic put(input int i, input request_t r);
    up.req_id[i] = r.id;
    up.req_address[i] = r.address;
    up.req_data[i] = r.data;
    up.req_write[i] = r.write;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (rst_n && dn.req_valid[0] && dn.req_taken[0]) begin
      request_t a, e;
      a = '{id: dn.req_id[0], address: dn.req_address[0], data: dn.req_data[0], write: dn.req_write[0]};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL ms_xfer: got %h expected no transfer", a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          fails++;
          $display("FAIL ms_xfer: got %h expected %h", a, e);
        end
      end
    end
  initial begin
    up.req_valid = '0;
    up.rsp_taken = '0;
    dn.req_taken = '0;
    dn.rsp_valid = '0;
    dn.rsp_id = '0;
    dn.rsp_data = '0;
    put(0, req(0, 0));
    put(1, req(1, 0));
    up.req_valid = 2'b11;
    repeat (2) @(negedge clk);
    chk("rst_req_taken", up.req_taken, 0);
    chk("rst_ms_valid", dn.req_valid, 0);
    chk("rst_ms_address", dn.req_address[0], 0);
    chk("rst_id_error", id_error, 0);
    tick;
    up.req_valid = '0;
    rst_n = 1'b1;
    tick;
    dn.req_taken = 1'b1;
    put(0, req(0, 'h100));
    up.req_valid = 2'b01;
    @(negedge clk);
    chk("t1_taken", up.req_taken, 2'b01);
    exp_q.push_back(req(0, 'h100));
    tick;
    up.req_valid = '0;
    @(negedge clk);
    chk("t1_ms_valid", dn.req_valid, 1);
    chk("t1_ms_address", dn.req_address[0], 'h100);
    tick;
    put(0, req(0, 'h200));
    put(1, req(1, 'h210));
    up.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_taken", up.req_taken, k % 2 == 0 ? 2'b10 : 2'b01);
      if (k > 0) chk("t2_ms_id", dn.req_id[0], k % 2 == 0 ? 4 : 8);
      exp_q.push_back(k % 2 == 0 ? req(1, 'h210) : req(0, 'h200));
      tick;
    end
    up.req_valid = '0;
    @(negedge clk);
    chk("t2_last_ms_id", dn.req_id[0], 4);
    tick;
    dn.req_taken = 1'b0;
    put(0, req(0, 'h300));
    up.req_valid = 2'b01;
    @(negedge clk);
    chk("t3_first_taken", up.req_taken, 2'b01);
    exp_q.push_back(req(0, 'h300));
    tick;
    put(0, req(0, 'h304));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_stall_taken", up.req_taken, 0);
      chk("t3_stall_ms_valid", dn.req_valid, 1);
      chk("t3_stall_ms_address", dn.req_address[0], 'h300);
      tick;
    end
    dn.req_taken = 1'b1;
    @(negedge clk);
    chk("t3_resume_taken", up.req_taken, 2'b01);
    exp_q.push_back(req(0, 'h304));
    tick;
    up.req_valid = '0;
    @(negedge clk);
    chk("t3_ms_address", dn.req_address[0], 'h304);
    tick;
    dn.rsp_id = 8'd9;
    dn.rsp_data = 24'h123456;
    dn.rsp_valid = 1'b1;
    up.rsp_taken = 2'b10;
    @(negedge clk);
    chk("t4_rsp_valid", up.rsp_valid, 2'b10);
    chk("t4_sm_taken", dn.rsp_taken, 1);
    chk("t4_rsp_id", up.rsp_id, 9);
    chk("t4_rsp_data", up.rsp_data, 'h123456);
    tick;
    up.rsp_taken = 2'b01;
    @(negedge clk);
    chk("t4_sm_taken_low", dn.rsp_taken, 0);
    chk("t4_rsp_valid_held", up.rsp_valid, 2'b10);
    up.rsp_taken = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick;
      dn.rsp_id = bid[k];
      @(negedge clk);
      chk("t4_edge_rsp_valid", up.rsp_valid, bv[k]);
      chk("t4_edge_sm_taken", dn.rsp_taken, 1);
    end
    chk("t4_id_error", id_error, 0);
    up.rsp_taken = '0;
    for (int k = 0; k < 3; k++) begin
      tick;
      dn.rsp_id = oid[k];
      @(negedge clk);
      chk("t5_rsp_valid", up.rsp_valid, 0);
      chk("t5_sm_taken", dn.rsp_taken, 1);
    end
    tick;
    dn.rsp_valid = 1'b0;
    @(negedge clk);
    chk("t5_id_error", id_error, 1);
    repeat (3) tick;
    @(negedge clk);
    chk("t5_id_error_held", id_error, 1);
    tick;
    dn.req_taken = 1'b0;
    put(0, req(0, 'h400));
    put(1, req(1, 'h410));
    up.req_valid = 2'b01;
    @(negedge clk);
    chk("t6_taken", up.req_taken, 2'b01);
    exp_q.push_back(req(0, 'h400));
    tick;
    up.req_valid = 2'b11;
    @(negedge clk);
    chk("t6_stall_ms_valid", dn.req_valid, 1);
    #2;
    rst_n = 1'b0;
    dn.req_taken = 1'b1;
    #1;
    chk("t6_rst_ms_valid", dn.req_valid, 0);
    chk("t6_rst_id_error", id_error, 0);
    chk("t6_rst_req_taken", up.req_taken, 0);
    exp_q.delete();
    tick;
    tick;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_after_taken", up.req_taken, 2'b01);
    exp_q.push_back(req(0, 'h400));
    tick;
    up.req_valid = '0;
    @(negedge clk);
    chk("t6_after_ms_id", dn.req_id[0], 4);
    tick;
    @(negedge clk);
    chk("end_ms_valid", dn.req_valid, 0);
    chk("end_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
